calc_stack_ctrl: RTL and testbench

Operand-stack controller for the calculator datapath. It turns push/pop commands into accesses on the 32-bit word memory: it drives `address`/`data`/`we` and samples the memory's combinational `data_out`. It tracks the stack pointer, full/empty and error status, so the ALU sequencer sees a LIFO instead of raw memory.

---
 rtl/calc_pkg.sv | 14 +
 rtl/calc_stack_ctrl.sv | 131 +++++++++++++
 tb/tb_calc_stack_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: controller state encoding
// and default datapath widths.
package calc_pkg;

    localparam int unsigned CALC_DATA_W = 32;
    localparam int unsigned CALC_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage : calc_pkg

// File: rtl/calc_stack_ctrl.sv
// Operand-stack controller: maps push/pop/clear commands onto a word memory
// with a combinational read port, presenting a LIFO with full/empty/err status.
module calc_stack_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = CALC_ADDR_W,
    parameter int unsigned DATA_W    = CALC_DATA_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       cmd_ready,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_data_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    if (longint'(BASE_ADDR) + longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_param_chk
        $error("calc_stack_ctrl: BASE_ADDR+DEPTH exceeds the address space");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic                full_c, empty_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        we_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (push && pop) begin
                    err_d = 1'b1;
                end else if (push) begin
                    if (full_c) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = BASE + ADDR_W'(count_q);
                        wdata_d = push_data;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end
                end else if (pop) begin
                    if (empty_c) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = BASE + ADDR_W'(count_q) - ADDR_W'(1);
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + CW'(1);
                state_d = IDLE;
            end
            READ: begin
                rdata_d  = mem_data_out;
                rvalid_d = 1'b1;
                count_d  = count_q - CW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write enable has its own flop so the memory sees a clean, register-driven strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            addr_q   <= BASE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            we_q     <= we_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign resp_valid  = rvalid_q;
    assign resp_data   = rdata_q;
    assign count       = count_q;
    assign full        = full_c;
    assign empty       = empty_c;
    assign err         = err_q;
    assign mem_address = addr_q;
    assign mem_data    = wdata_q;
    assign mem_we      = we_q;

endmodule : calc_stack_ctrl

// File: tb/tb_calc_stack_ctrl.sv
// Directed bench for calc_stack_ctrl with a behavioural 32-bit word memory
// that commits on the negedge and reads combinationally.
module tb_calc_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push, pop, clear;
    logic [31:0] push_data;
    logic        cmd_ready, resp_valid, full, empty, err, mem_we;
    logic [31:0] resp_data, mem_data, mem_data_out;
    logic [3:0]  count;
    logic [7:0]  mem_address;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned exp_cnt     = 0;
    int unsigned wr_cnt      = 0;

    logic [31:0] mem_model [256];

    calc_stack_ctrl #(
        .DEPTH    (8),
        .ADDR_W   (8),
        .DATA_W   (32),
        .BASE_ADDR(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .clear       (clear),
        .push_data   (push_data),
        .cmd_ready   (cmd_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err         (err),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            mem_model[mem_address] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign mem_data_out = mem_model[mem_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 1);
    endtask

    task automatic do_push(input logic [31:0] d);
        int unsigned w0;
        wait_ready();
        w0 = wr_cnt;
        push = 1'b1;
        push_data = d;
        tick();
        push = 1'b0;
        chk("push_we", 32'(mem_we), 1);
        chk("push_busy", 32'(cmd_ready), 0);
        chk("push_addr", 32'(mem_address), exp_cnt);
        chk("push_cnt_hold", 32'(count), exp_cnt);
        tick();
        exp_cnt++;
        chk("push_we_off", 32'(mem_we), 0);
        chk("push_cnt", 32'(count), exp_cnt);
        chk("push_wr_once", wr_cnt - w0, 1);
        chk("push_mem", mem_model[exp_cnt-1], d);
    endtask

    task automatic do_pop(input logic [31:0] expd);
        wait_ready();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("pop_busy", 32'(cmd_ready), 0);
        chk("pop_we", 32'(mem_we), 0);
        chk("pop_addr", 32'(mem_address), exp_cnt - 1);
        chk("pop_rvalid_early", 32'(resp_valid), 0);
        tick();
        exp_cnt--;
        chk("pop_rvalid", 32'(resp_valid), 1);
        chk("pop_data", resp_data, expd);
        chk("pop_cnt", 32'(count), exp_cnt);
    endtask

    task automatic do_reject(input logic p, input logic q, input string tag);
        int unsigned w0;
        wait_ready();
        w0 = wr_cnt;
        push = p;
        pop = q;
        push_data = 32'hDEAD_BEEF;
        tick();
        push = 1'b0;
        pop = 1'b0;
        chk({tag, "_err"}, 32'(err), 1);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_cnt"}, 32'(count), exp_cnt);
        tick();
        chk({tag, "_err_off"}, 32'(err), 0);
        chk({tag, "_nowr"}, wr_cnt - w0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] words [8];
        int unsigned w0;
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        rst_n = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
        push_data = '0;
        #3;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_wdata", mem_data, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rvalid", 32'(resp_valid), 0);
        chk("rst_err", 32'(err), 0);
        #9 rst_n = 1'b1;
        tick();

        // LIFO order
        do_push(32'h1111_1111);
        do_push(32'h2222_2222);
        do_push(32'h3333_3333);
        chk("three_cnt", 32'(count), 3);
        chk("three_wr", wr_cnt, 3);
        do_pop(32'h3333_3333);
        tick();
        chk("rvalid_pulse", 32'(resp_valid), 0);
        chk("rdata_held", resp_data, 32'h3333_3333);
        do_pop(32'h2222_2222);
        do_pop(32'h1111_1111);
        chk("lifo_empty", 32'(empty), 1);

        // full / empty boundaries
        for (int i = 0; i < 8; i++) begin
            words[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            do_push(words[i]);
        end
        chk("full_flag", 32'(full), 1);
        chk("full_empty", 32'(empty), 0);
        do_reject(1'b1, 1'b0, "push_full");
        for (int i = 7; i >= 0; i--) do_pop(words[i]);
        chk("drain_empty", 32'(empty), 1);
        do_reject(1'b0, 1'b1, "pop_empty");

        // simultaneous push/pop, then clear
        for (int i = 0; i < 5; i++) do_push(32'h5000_0000 + 32'(i));
        do_reject(1'b1, 1'b1, "push_pop");
        w0 = wr_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_cnt = 0;
        chk("clear_cnt", 32'(count), 0);
        chk("clear_we", 32'(mem_we), 0);
        chk("clear_err", 32'(err), 0);
        chk("clear_empty", 32'(empty), 1);
        tick();
        chk("clear_nowr", wr_cnt - w0, 0);

        // push held through the busy cycle is accepted only once
        w0 = wr_cnt;
        push = 1'b1;
        push_data = 32'h7777_7777;
        tick();
        chk("hold_busy", 32'(cmd_ready), 0);
        push_data = 32'h8888_8888;
        tick();
        push = 1'b0;
        chk("hold_err", 32'(err), 0);
        chk("hold_cnt", 32'(count), 1);
        tick();
        chk("hold_cnt2", 32'(count), 1);
        chk("hold_wr", wr_cnt - w0, 1);
        chk("hold_mem", mem_model[0], 32'h7777_7777);
        exp_cnt = 1;

        // reset during WRITE
        push = 1'b1;
        push_data = 32'h9999_9999;
        tick();
        push = 1'b0;
        chk("wr_we_before_rst", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 0);
        chk("rst_mid_cnt", 32'(count), 0);
        chk("rst_mid_ready", 32'(cmd_ready), 1);
        #4 rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        do_reject(1'b0, 1'b1, "pop_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_calc_stack_ctrl
